tlb_search_arb: RTL

Arbiter that shares the single TLB search port among three requesters: instruction fetch (pre-IF address translation), data access (MEM-stage load/store translation) and CP0 TLBP. Each cycle it grants at most one requester, drives its lookup onto the TLB search port (combinational TLB), captures the result into that requester's private result registers, and returns it with a one-cycle `*_rvalid` pulse. It sits between the pipeline stages/CP0 and the `tlb` module's search port 0; search port 1 is freed for TLBR/TLBWI-side use.

---
 rtl/tlb_search_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tlb_search_arb.sv
// Shares the single TLB search port among fetch, data access and CP0 TLBP lookups.
// Build option: define TLB_ARB_RR_EN for round-robin between mem and if (cp0 stays highest).
module tlb_search_arb #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            tlb_write,

  input  logic            if_req,
  input  logic [18:0]     if_vpn2,
  input  logic            if_odd_page,
  input  logic [7:0]      if_asid,
  input  logic            if_cancel,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic            if_found,
  output logic [IDXW-1:0] if_index,
  output logic [19:0]     if_pfn,
  output logic [2:0]      if_c,
  output logic            if_d,
  output logic            if_v,

  input  logic            mem_req,
  input  logic [18:0]     mem_vpn2,
  input  logic            mem_odd_page,
  input  logic [7:0]      mem_asid,
  output logic            mem_gnt,
  output logic            mem_rvalid,
  output logic            mem_found,
  output logic [IDXW-1:0] mem_index,
  output logic [19:0]     mem_pfn,
  output logic [2:0]      mem_c,
  output logic            mem_d,
  output logic            mem_v,

  input  logic            cp0_req,
  input  logic [18:0]     cp0_vpn2,
  input  logic [7:0]      cp0_asid,
  output logic            cp0_gnt,
  output logic            cp0_rvalid,
  output logic            cp0_found,
  output logic [IDXW-1:0] cp0_index,

  output logic [18:0]     s_vpn2,
  output logic            s_odd_page,
  output logic [7:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  input  logic [19:0]     s_pfn,
  input  logic [2:0]      s_c,
  input  logic            s_d,
  input  logic            s_v
);

  logic if_vld_p1;
  logic elig_p0;

  // Stage p0: grant selection and search key mux (same cycle as the TLB lookup)
`ifdef TLB_ARB_RR_EN
  logic rr_last_mem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rr_last_mem <= 1'b0;
    else if (mem_gnt || if_gnt)
      rr_last_mem <= mem_gnt;
  end

  always_comb begin
    elig_p0 = ~tlb_write & ~cp0_req;
    cp0_gnt = cp0_req & ~tlb_write;
    mem_gnt = elig_p0 & mem_req & (~if_req | ~rr_last_mem);
    if_gnt  = elig_p0 & if_req  & (~mem_req | rr_last_mem);
  end
`else
  always_comb begin
    elig_p0 = ~tlb_write & ~cp0_req;
    cp0_gnt = cp0_req & ~tlb_write;
    mem_gnt = elig_p0 & mem_req;
    if_gnt  = elig_p0 & if_req & ~mem_req;
  end
`endif

  always_comb begin
    s_vpn2     = '0;
    s_odd_page = 1'b0;
    s_asid     = '0;
    if (cp0_gnt) begin
      s_vpn2 = cp0_vpn2;
      s_asid = cp0_asid;
    end else if (mem_gnt) begin
      s_vpn2     = mem_vpn2;
      s_odd_page = mem_odd_page;
      s_asid     = mem_asid;
    end else if (if_gnt) begin
      s_vpn2     = if_vpn2;
      s_odd_page = if_odd_page;
      s_asid     = if_asid;
    end
  end

  // Stage p1: per-requester result registers and response strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_vld_p1  <= 1'b0;
      mem_rvalid <= 1'b0;
      cp0_rvalid <= 1'b0;
      if_found   <= 1'b0;
      if_index   <= '0;
      if_pfn     <= '0;
      if_c       <= '0;
      if_d       <= 1'b0;
      if_v       <= 1'b0;
      mem_found  <= 1'b0;
      mem_index  <= '0;
      mem_pfn    <= '0;
      mem_c      <= '0;
      mem_d      <= 1'b0;
      mem_v      <= 1'b0;
      cp0_found  <= 1'b0;
      cp0_index  <= '0;
    end else begin
      if_vld_p1  <= if_gnt & ~if_cancel;
      mem_rvalid <= mem_gnt;
      cp0_rvalid <= cp0_gnt;
      if (if_gnt) begin
        if_found <= s_found;
        if_index <= s_index;
        if_pfn   <= s_pfn;
        if_c     <= s_c;
        if_d     <= s_d;
        if_v     <= s_v;
      end
      if (mem_gnt) begin
        mem_found <= s_found;
        mem_index <= s_index;
        mem_pfn   <= s_pfn;
        mem_c     <= s_c;
        mem_d     <= s_d;
        mem_v     <= s_v;
      end
      if (cp0_gnt) begin
        cp0_found <= s_found;
        cp0_index <= s_index;
      end
    end
  end

  // A flush arriving in the response cycle still kills the pulse
  assign if_rvalid = if_vld_p1 & ~if_cancel;

endmodule
